ic_bvsge_bvmul_search: RTL and testbench
========================================

IC_BVSGE_BVMUL_SEARCH -- requirements
Module: ic_bvsge_bvmul_search

Interface
REQ-001 Parameter: W, default 4, bit-vector width of s, t, x.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 mode  input  1  0 = check candidate only, 1 = exhaustive witness search.
REQ-007 s  input  W  multiplier operand of bvmul(x, s).
REQ-008 t  input  W  signed bound of bvsge(bvmul(x, s), t).
REQ-009 x_cand  input  W  candidate witness, e.g. from the Skolem-function block.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 cand_ok  output  1  bvsge(x_cand*s, t) holds.
REQ-013 sat  output  1  some x satisfies the formula (search mode; equals cand_ok in check mode).
REQ-014 witness  output  W  smallest satisfying x (search); x_cand in check mode; 0 if unsat.

Function
REQ-015 Predicate P(x) SHALL be: low W bits of x*s, two's-complement compared >= t; no overflow detection.
REQ-016 States SHALL be IDLE, SEARCH, DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; acceptance = in_valid & in_ready.
REQ-018 On acceptance, s, t, x_cand, mode SHALL be registered; cand_ok = P(x_cand) registered same edge.
REQ-019 Check mode: IDLE -> DONE on acceptance; out_valid asserted the cycle after acceptance.
REQ-020 Search mode: IDLE -> SEARCH, counter x = 0; one x evaluated per cycle, using registered s, t.
REQ-021 SEARCH: P(x)=1 -> DONE, witness = x, sat = 1; out_valid asserted k+1 cycles after acceptance for first hit at x = k.
REQ-022 SEARCH: x = 2^W-1 and P(x)=0 -> DONE, sat = 0, witness = 0; out_valid 2^W cycles after acceptance.
REQ-023 Counter SHALL not wrap; terminal value 2^W-1 evaluated exactly once.
REQ-024 DONE: outputs held stable while out_valid & ~out_ready; DONE -> IDLE on out_valid & out_ready.
REQ-025 in_ready SHALL be 0 in the DONE cycle; new request accepted no earlier than the cycle after handshake.
REQ-026 Inputs s, t, x_cand, mode changing after acceptance SHALL not affect the current result.

Reset
REQ-027 rst_n = 0 at a clock edge SHALL force IDLE, counter 0, out_valid 0, cand_ok 0, sat 0, witness 0; in_ready = 1 from the first cycle after reset.
REQ-028 Reset during SEARCH or DONE SHALL abort the operation; no result emitted for it.

Structure
REQ-029 Shared package ic_bvmul_pkg SHALL hold the state enum and default W.
REQ-030 One sub-module ic_bvsge_bvmul_eval (combinational P(x) for given s, t), instantiated twice: candidate and search counter.

Verification (W = 4)
REQ-031 s=0, t=0, mode=1 -> sat=1, witness=0, out_valid 1 cycle after acceptance.
REQ-032 s=0, t=1, mode=1 -> sat=0, witness=0, out_valid 16 cycles after acceptance.
REQ-033 s=1, t=7, mode=1 -> witness=7, sat=1, out_valid 8 cycles after acceptance; s=2, t=7 -> sat=0.
REQ-034 s=4'hF, t=5, mode=1, x_cand=11 -> witness=9, sat=1, cand_ok=1.
REQ-035 s=3, t=4'h8, x_cand=5, mode=0 -> cand_ok=1, sat=1, witness=5 one cycle later; out_ready held 0 for 3 cycles -> outputs stable, in_ready=0.
REQ-036 rst_n low in 4th SEARCH cycle of s=0, t=1 -> IDLE next cycle, out_valid never asserted; following request s=1, t=7 completes per REQ-033.

Source files
------------

// File: rtl/ic_bvmul_pkg.sv
// Shared definitions for the bvsge(bvmul(x, s), t) witness search block:
// default bit-vector width and the controller state encoding.
package ic_bvmul_pkg;

    localparam int unsigned W_DEFAULT = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SEARCH = 2'd1;
    localparam state_t ST_DONE   = 2'd2;

endpackage

// File: rtl/ic_bvsge_bvmul.sv
// Width sanity helper for the bvsge(bvmul(x, s), t) search top.
module ic_bvsge_bvmul_width_chk
    import ic_bvmul_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    output logic ok_c
);

    // Widths below 1 make the search degenerate.
    always_comb begin
        ok_c = (W >= 1);
    end

endmodule

// File: rtl/ic_bvsge_bvmul_eval.sv
// Combinational predicate P(x) = bvsge(bvmul(x, s), t).
// Ports:
//   x, s, t : W-bit operands
//   p_c     : 1 when the low W bits of x*s, read as signed, are >= signed t
module ic_bvsge_bvmul_eval
    import ic_bvmul_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] s,
    input  logic [W-1:0] t,
    output logic         p_c
);

    logic [W-1:0] prod_c;

    // Product wraps modulo 2^W; overflow is intentionally ignored.
    always_comb begin
        prod_c = W'(x * s);
        p_c    = ($signed(prod_c) >= $signed(t));
    end

endmodule

// File: rtl/ic_bvsge_bvmul_search.sv
// Check or exhaustively search for x satisfying bvsge(bvmul(x, s), t).
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid / in_ready : request handshake (ready only in IDLE)
//   mode                : 0 = check x_cand only, 1 = search x = 0 .. 2^W-1
//   s, t, x_cand        : operands, captured on acceptance
//   out_valid/out_ready : result handshake, result held until accepted
//   cand_ok             : P(x_cand)
//   sat                 : a satisfying x exists (cand_ok in check mode)
//   witness             : smallest satisfying x, x_cand in check mode, 0 if unsat
module ic_bvsge_bvmul_search
    import ic_bvmul_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    input  logic [W-1:0] s,
    input  logic [W-1:0] t,
    input  logic [W-1:0] x_cand,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         cand_ok,
    output logic         sat,
    output logic [W-1:0] witness
);

    localparam logic [W-1:0] X_MAX = {W{1'b1}};

    state_t       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] s_q, s_d;
    logic [W-1:0] t_q, t_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic         cand_ok_q, cand_ok_d;
    logic         sat_q, sat_d;
    logic [W-1:0] witness_q, witness_d;

    logic cand_p_c;
    logic srch_p_c;

    // Candidate is judged on the live inputs so the verdict lands on the accept edge.
    ic_bvsge_bvmul_eval #(.W(W)) u_eval_cand (
        .x   (x_cand),
        .s   (s),
        .t   (t),
        .p_c (cand_p_c)
    );

    // Search uses captured operands so later input changes cannot disturb it.
    ic_bvsge_bvmul_eval #(.W(W)) u_eval_srch (
        .x   (cnt_q),
        .s   (s_q),
        .t   (t_q),
        .p_c (srch_p_c)
    );

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        s_d         = s_q;
        t_d         = t_q;
        out_valid_d = out_valid_q;
        cand_ok_d   = cand_ok_q;
        sat_d       = sat_q;
        witness_d   = witness_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    s_d       = s;
                    t_d       = t;
                    cand_ok_d = cand_p_c;
                    cnt_d     = '0;
                    if (mode) begin
                        state_d     = ST_SEARCH;
                        out_valid_d = 1'b0;
                        sat_d       = 1'b0;
                        witness_d   = '0;
                    end else begin
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                        sat_d       = cand_p_c;
                        witness_d   = x_cand;
                    end
                end
            end
            ST_SEARCH: begin
                if (srch_p_c) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    sat_d       = 1'b1;
                    witness_d   = cnt_q;
                end else if (cnt_q == X_MAX) begin
                    // Last value already tried: stop without wrapping.
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    sat_d       = 1'b0;
                    witness_d   = '0;
                end else begin
                    cnt_d = cnt_q + W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        in_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            s_q         <= '0;
            t_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cand_ok_q   <= 1'b0;
            sat_q       <= 1'b0;
            witness_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            s_q         <= s_d;
            t_q         <= t_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            cand_ok_q   <= cand_ok_d;
            sat_q       <= sat_d;
            witness_q   <= witness_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign cand_ok   = cand_ok_q;
    assign sat       = sat_q;
    assign witness   = witness_q;

endmodule

// File: tb/tb_ic_bvsge_bvmul_search.sv
// Directed, table-driven bench for ic_bvsge_bvmul_search at W = 4.
// Latency is counted in rising edges after the accepting edge until out_valid is seen.
module tb_ic_bvsge_bvmul_search;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       mode;
    logic [3:0] s;
    logic [3:0] t;
    logic [3:0] x_cand;
    logic       out_valid;
    logic       out_ready;
    logic       cand_ok;
    logic       sat;
    logic [3:0] witness;

    int checks;
    int errors;

    ic_bvsge_bvmul_search #(.W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .s         (s),
        .t         (t),
        .x_cand    (x_cand),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cand_ok   (cand_ok),
        .sat       (sat),
        .witness   (witness)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       mode;
        logic [3:0] s;
        logic [3:0] t;
        logic [3:0] xc;
        logic       exp_ok;
        logic       exp_sat;
        logic [3:0] exp_wit;
        int         exp_lat;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present one request in IDLE; returns the observed latency.
    task automatic send(input logic m, input logic [3:0] sv, input logic [3:0] tv,
                        input logic [3:0] xv, output int lat);
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        mode = m; s = sv; t = tv; x_cand = xv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Later input changes must not disturb the result.
        mode = 1'($urandom); s = 4'($urandom); t = 4'($urandom); x_cand = 4'($urandom);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
        chk("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_vec(input int i);
        int lat;
        string tag;
        tag = $sformatf("v%0d", i);
        send(vecs[i].mode, vecs[i].s, vecs[i].t, vecs[i].xc, lat);
        chk({tag, "_latency"}, 32'(lat), 32'(vecs[i].exp_lat));
        chk({tag, "_cand_ok"}, {31'd0, cand_ok}, {31'd0, vecs[i].exp_ok});
        chk({tag, "_sat"}, {31'd0, sat}, {31'd0, vecs[i].exp_sat});
        chk({tag, "_witness"}, {28'd0, witness}, {28'd0, vecs[i].exp_wit});
        chk({tag, "_in_ready_done"}, {31'd0, in_ready}, 32'd0);
        handshake();
    endtask

    initial begin
        int lat;
        int seen;
        checks = 0;
        errors = 0;

        //          mode  s      t      xc     ok    sat   wit    lat
        vecs[0]  = '{1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 4'h0,  1};
        vecs[1]  = '{1'b1, 4'h0, 4'h1, 4'h3, 1'b0, 1'b0, 4'h0, 16};
        vecs[2]  = '{1'b1, 4'h1, 4'h7, 4'h0, 1'b0, 1'b1, 4'h7,  8};
        vecs[3]  = '{1'b1, 4'h2, 4'h7, 4'h3, 1'b0, 1'b0, 4'h0, 16};
        vecs[4]  = '{1'b1, 4'hF, 4'h5, 4'hB, 1'b1, 1'b1, 4'h9, 10};
        vecs[5]  = '{1'b1, 4'h3, 4'h4, 4'h2, 1'b1, 1'b1, 4'h2,  3};
        vecs[6]  = '{1'b0, 4'h3, 4'h8, 4'h5, 1'b1, 1'b1, 4'h5,  0};
        vecs[7]  = '{1'b0, 4'h2, 4'h1, 4'h4, 1'b0, 1'b0, 4'h4,  0};
        vecs[8]  = '{1'b0, 4'h5, 4'h0, 4'h3, 1'b0, 1'b0, 4'h3,  0};
        vecs[9]  = '{1'b0, 4'h3, 4'h2, 4'h1, 1'b1, 1'b1, 4'h1,  0};
        vecs[10] = '{1'b1, 4'h7, 4'hF, 4'h0, 1'b1, 1'b1, 4'h0,  1};
        vecs[11] = '{1'b1, 4'h4, 4'h4, 4'h1, 1'b1, 1'b1, 4'h1,  2};
        // First and only hit at the terminal counter value 15 (9*15 mod 16 = 7).
        vecs[12] = '{1'b1, 4'h9, 4'h7, 4'h0, 1'b0, 1'b1, 4'hF, 16};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        mode = 1'b0; s = '0; t = '0; x_cand = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_cand_ok", {31'd0, cand_ok}, 32'd0);
        chk("rst_sat", {31'd0, sat}, 32'd0);
        chk("rst_witness", {28'd0, witness}, 32'd0);

        for (int i = 0; i < NV; i++) run_vec(i);

        // Back-pressure: result must hold while out_ready stays low.
        send(1'b0, 4'h3, 4'h8, 4'h5, lat);
        chk("stall_latency", 32'(lat), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("stall%0d_out_valid", c), {31'd0, out_valid}, 32'd1);
            chk($sformatf("stall%0d_cand_ok", c), {31'd0, cand_ok}, 32'd1);
            chk($sformatf("stall%0d_sat", c), {31'd0, sat}, 32'd1);
            chk($sformatf("stall%0d_witness", c), {28'd0, witness}, 32'd5);
            chk($sformatf("stall%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
        end
        handshake();

        // Reset in the 4th search cycle of an unsat search aborts it silently.
        chk("abort_in_ready_idle", {31'd0, in_ready}, 32'd1);
        mode = 1'b1; s = 4'h0; t = 4'h1; x_cand = 4'h0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        chk("abort_no_result", 32'(seen), 32'd0);
        run_vec(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
